zoom_coord_pipe: RTL and testbench

//  Parametrised successor to the zoom coordinate datapath. It maps each VGA scan coordinate
//  to a source-image pixel coordinate and a framebuffer address, for 5 zoom modes. The scaled

---
 rtl/zoom_coord_pipe.sv | 226 ++++++++++++++++++++++
 tb/tb_zoom_coord_pipe.sv | 368 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/zoom_coord_pipe.sv
// zoom_coord_pipe
// Maps each VGA scan coordinate to a source-image pixel coordinate and a
// framebuffer address. It supports five zoom modes and centres the scaled
// image on the display, cropping it when it is larger than the display.
// The datapath is a 3-stage valid/ready pipeline. A requested mode change is
// held as pending and takes effect on the first accepted frame-start beat (0,0).
//
// Ports
//   clk_in       in   system clock
//   reset        in   asynchronous active-low reset
//   in_valid     in   next_x/next_y carry a valid coordinate beat
//   in_ready     out  pipeline accepts a beat this cycle
//   next_x/y     in   display coordinate (COORD_W bits)
//   ch           in   requested zoom mode, sampled when mode_req=1
//   mode_req     in   one-cycle mode change request
//   mode_done    out  one-cycle pulse: the pending mode became active
//   mode_err     out  one-cycle pulse: mode_req carried an invalid ch
//   active_mode  out  mode applied to beats entering stage 1
//   out_valid    out  output beat valid
//   out_ready    in   downstream accepts the output beat
//   img_x/img_y  out  source pixel coordinate (0 outside the image)
//   in_img       out  display pixel lies inside the scaled image
//   address      out  img_y*SRC_W+img_x (0 outside the image)
module zoom_coord_pipe #(
  parameter int SRC_W   = 320,
  parameter int SRC_H   = 240,
  parameter int DST_W   = 640,
  parameter int DST_H   = 480,
  parameter int COORD_W = 10,
  parameter int ADDR_W  = 17
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [COORD_W-1:0] next_x,
  input  logic [COORD_W-1:0] next_y,
  input  logic [2:0]         ch,
  input  logic               mode_req,
  output logic               mode_done,
  output logic               mode_err,
  output logic [2:0]         active_mode,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [COORD_W-1:0] img_x,
  output logic [COORD_W-1:0] img_y,
  output logic               in_img,
  output logic [ADDR_W-1:0]  address
);

  localparam int CW = COORD_W + 3;
  typedef logic signed [CW-1:0] sCoord_t;

  // Shift amount that implements the scale factor for each mode.
  function automatic logic [1:0] log2k(input logic [2:0] m);
    case (m)
      3'd1, 3'd3: return 2'd1;
      3'd2, 3'd4: return 2'd2;
      default:    return 2'd0;
    endcase
  endfunction

  function automatic logic zoomOut(input logic [2:0] m);
    return (m == 3'd3) || (m == 3'd4);
  endfunction

  // Compute the scaled image extent along one axis.
  function automatic sCoord_t scaled(input int base, input logic [2:0] m);
    int r;
    case (m)
      3'd1:    r = base * 2;
      3'd2:    r = base * 4;
      3'd3:    r = base / 2;
      3'd4:    r = base / 4;
      default: r = base;
    endcase
    return sCoord_t'(r);
  endfunction

  // Compute the centring offset. It is negative when the scaled image is
  // cropped, so the halving must be an arithmetic shift.
  function automatic sCoord_t offset(input int dst, input int src, input logic [2:0] m);
    sCoord_t s;
    s = scaled(src, m);
    return (sCoord_t'(dst) - s) >>> 1;
  endfunction

  logic [2:0]         r_activeMode;
  logic [2:0]         r_pendMode;
  logic               r_pendValid;
  logic               r_modeDone;
  logic               r_modeErr;
  sCoord_t            r_offX;
  sCoord_t            r_offY;

  logic               r_s1Valid;
  sCoord_t            r_s1U;
  sCoord_t            r_s1V;
  logic [2:0]         r_s1Mode;

  logic               r_s2Valid;
  logic               r_s2InImg;
  logic [COORD_W-1:0] r_s2SrcX;
  logic [COORD_W-1:0] r_s2SrcY;

  logic               r_s3Valid;
  logic               r_s3InImg;
  logic [COORD_W-1:0] r_s3X;
  logic [COORD_W-1:0] r_s3Y;
  logic [ADDR_W-1:0]  r_s3Addr;

  logic               w_advance;
  logic               w_accept;
  logic               w_origin;
  logic               w_apply;
  logic [2:0]         w_effMode;
  sCoord_t            w_offX;
  sCoord_t            w_offY;
  sCoord_t            w_u;
  sCoord_t            w_v;
  sCoord_t            w_sw;
  sCoord_t            w_sh;
  logic               w_inImg;
  logic [1:0]         w_shift;
  logic [COORD_W-1:0] w_srcX;
  logic [COORD_W-1:0] w_srcY;
  logic [ADDR_W-1:0]  w_addr;

  // All stages move together whenever the output slot is empty or is being
  // drained. A pending mode is applied to the frame-start beat in the same
  // cycle it is accepted, so that beat already uses the new offsets.
  assign w_advance = out_ready | ~r_s3Valid;
  assign w_accept  = in_valid & w_advance;
  assign w_origin  = (next_x == '0) && (next_y == '0);
  assign w_apply   = w_accept & w_origin & r_pendValid;
  assign w_effMode = w_apply ? r_pendMode : r_activeMode;
  assign w_offX    = w_apply ? offset(DST_W, SRC_W, r_pendMode) : r_offX;
  assign w_offY    = w_apply ? offset(DST_H, SRC_H, r_pendMode) : r_offY;
  assign w_u       = $signed({3'b000, next_x}) - w_offX;
  assign w_v       = $signed({3'b000, next_y}) - w_offY;

  // Stage 2 combinational part. The bounds test uses the mode that travelled
  // with the beat, so a mode switch never tears beats already in flight.
  assign w_sw    = scaled(SRC_W, r_s1Mode);
  assign w_sh    = scaled(SRC_H, r_s1Mode);
  assign w_inImg = !r_s1U[CW-1] && (r_s1U < w_sw) && !r_s1V[CW-1] && (r_s1V < w_sh);
  assign w_shift = log2k(r_s1Mode);
  assign w_srcX  = COORD_W'(zoomOut(r_s1Mode) ? (r_s1U << w_shift) : (r_s1U >>> w_shift));
  assign w_srcY  = COORD_W'(zoomOut(r_s1Mode) ? (r_s1V << w_shift) : (r_s1V >>> w_shift));

  assign w_addr = ADDR_W'(r_s2SrcY) * ADDR_W'(SRC_W) + ADDR_W'(r_s2SrcX);

  // Mode control. A valid request overwrites any pending mode, including one
  // that is applied in the same cycle: the new request then waits for the
  // next frame start. Invalid codes only raise the error pulse.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_activeMode <= 3'd0;
      r_pendMode   <= 3'd0;
      r_pendValid  <= 1'b0;
      r_modeDone   <= 1'b0;
      r_modeErr    <= 1'b0;
      r_offX       <= offset(DST_W, SRC_W, 3'd0);
      r_offY       <= offset(DST_H, SRC_H, 3'd0);
    end else begin
      r_modeDone <= w_apply;
      r_modeErr  <= mode_req && (ch > 3'd4);
      if (w_apply) begin
        r_activeMode <= r_pendMode;
        r_offX       <= w_offX;
        r_offY       <= w_offY;
      end
      if (mode_req && (ch <= 3'd4)) begin
        r_pendValid <= 1'b1;
        r_pendMode  <= ch;
      end else if (w_apply) begin
        r_pendValid <= 1'b0;
      end
    end
  end

  // The pipeline registers. Bubbles move through as valid=0, and out-of-image
  // beats are forced to zero when they enter the output stage.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      r_s1Valid <= 1'b0;
      r_s1U     <= '0;
      r_s1V     <= '0;
      r_s1Mode  <= 3'd0;
      r_s2Valid <= 1'b0;
      r_s2InImg <= 1'b0;
      r_s2SrcX  <= '0;
      r_s2SrcY  <= '0;
      r_s3Valid <= 1'b0;
      r_s3InImg <= 1'b0;
      r_s3X     <= '0;
      r_s3Y     <= '0;
      r_s3Addr  <= '0;
    end else if (w_advance) begin
      r_s1Valid <= in_valid;
      r_s1U     <= w_u;
      r_s1V     <= w_v;
      r_s1Mode  <= w_effMode;
      r_s2Valid <= r_s1Valid;
      r_s2InImg <= w_inImg;
      r_s2SrcX  <= w_srcX;
      r_s2SrcY  <= w_srcY;
      r_s3Valid <= r_s2Valid;
      r_s3InImg <= r_s2InImg;
      r_s3X     <= r_s2InImg ? r_s2SrcX : '0;
      r_s3Y     <= r_s2InImg ? r_s2SrcY : '0;
      r_s3Addr  <= r_s2InImg ? w_addr : '0;
    end
  end

  assign in_ready    = w_advance;
  assign mode_done   = r_modeDone;
  assign mode_err    = r_modeErr;
  assign active_mode = r_activeMode;
  assign out_valid   = r_s3Valid;
  assign img_x       = r_s3X;
  assign img_y       = r_s3Y;
  assign in_img      = r_s3InImg;
  assign address     = r_s3Addr;

endmodule

// File: tb/tb_zoom_coord_pipe.sv
// tb_zoom_coord_pipe
// Self-checking bench for zoom_coord_pipe. It uses a table of directed
// vectors, hand-written mode and handshake sequences, and a randomized stream.
// Each check is made against a cycle-level occupancy model. That model's data
// comes from a plain-arithmetic reference mapping.
module tb_zoom_coord_pipe;

  localparam int SRC_W   = 320;
  localparam int SRC_H   = 240;
  localparam int DST_W   = 640;
  localparam int DST_H   = 480;
  localparam int COORD_W = 10;
  localparam int ADDR_W  = 17;

  logic               clk_in = 1'b0;
  logic               reset = 1'b0;
  logic               in_valid = 1'b0;
  logic               in_ready;
  logic [COORD_W-1:0] next_x = '0;
  logic [COORD_W-1:0] next_y = '0;
  logic [2:0]         ch = '0;
  logic               mode_req = 1'b0;
  logic               mode_done;
  logic               mode_err;
  logic [2:0]         active_mode;
  logic               out_valid;
  logic               out_ready = 1'b1;
  logic [COORD_W-1:0] img_x;
  logic [COORD_W-1:0] img_y;
  logic               in_img;
  logic [ADDR_W-1:0]  address;

  zoom_coord_pipe #(
    .SRC_W(SRC_W), .SRC_H(SRC_H), .DST_W(DST_W), .DST_H(DST_H),
    .COORD_W(COORD_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk_in(clk_in), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .next_x(next_x), .next_y(next_y), .ch(ch), .mode_req(mode_req),
    .mode_done(mode_done), .mode_err(mode_err), .active_mode(active_mode),
    .out_valid(out_valid), .out_ready(out_ready), .img_x(img_x), .img_y(img_y),
    .in_img(in_img), .address(address)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    bit inImg;
    int x;
    int y;
    int addr;
  } expT;

  typedef struct {
    int mode;
    int x;
    int y;
    bit inImg;
    int ix;
    int iy;
    int addr;
  } vecT;

  int  nChecks = 0;
  int  nFails = 0;
  bit  slotV[3];
  expT slotE[3];
  int  mActive;
  int  mPend;
  bit  mPendV;
  bit  expDone;
  bit  expErr;
  int  delivered;
  bit  lastAccepted;
  int  curMode;

  // Reference mapping taken directly from the zoom rules: scale the image,
  // centre it, and map the display pixel back to a source pixel.
  function automatic expT refMap(input int m, input int x, input int y);
    expT r;
    int  k, sw, sh, ox, oy, u, v;
    bit  zin;
    r = '{inImg: 1'b0, x: 0, y: 0, addr: 0};
    zin = 1'b1;
    case (m)
      1: k = 2;
      2: k = 4;
      3: begin k = 2; zin = 1'b0; end
      4: begin k = 4; zin = 1'b0; end
      default: k = 1;
    endcase
    sw = zin ? SRC_W * k : SRC_W / k;
    sh = zin ? SRC_H * k : SRC_H / k;
    ox = (DST_W - sw) >>> 1;
    oy = (DST_H - sh) >>> 1;
    u = x - ox;
    v = y - oy;
    r.inImg = (u >= 0) && (u < sw) && (v >= 0) && (v < sh);
    if (r.inImg) begin
      r.x = zin ? u / k : u * k;
      r.y = zin ? v / k : v * k;
      r.addr = r.y * SRC_W + r.x;
    end
    return r;
  endfunction

  // Compare one value against its expected value and report any difference.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFails++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive all DUT inputs for the coming cycle.
  task automatic applyStimulus(input bit v, input int x, input int y, input bit req,
                               input int c, input bit ordy);
    in_valid  = v;
    next_x    = COORD_W'(x);
    next_y    = COORD_W'(y);
    mode_req  = req;
    ch        = 3'(c);
    out_ready = ordy;
  endtask

  task automatic modelReset();
    for (int i = 0; i < 3; i++) slotV[i] = 1'b0;
    mActive = 0;
    mPend   = 0;
    mPendV  = 1'b0;
    expDone = 1'b0;
    expErr  = 1'b0;
    curMode = 0;
  endtask

  // Run one clock cycle. Outputs are checked 1 ns after the falling edge,
  // then the model moves by one rising edge, just as the hardware does.
  task automatic tick();
    bit  adv, acc, apply, nDone, nErr;
    int  eff;
    expT e;
    #1;
    adv = !slotV[2] || out_ready;
    checkOutput("in_ready", in_ready, adv);
    checkOutput("out_valid", out_valid, slotV[2]);
    if (slotV[2]) begin
      checkOutput("in_img", in_img, slotE[2].inImg);
      checkOutput("img_x", img_x, slotE[2].x);
      checkOutput("img_y", img_y, slotE[2].y);
      checkOutput("address", address, slotE[2].addr);
    end
    checkOutput("mode_done", mode_done, expDone);
    checkOutput("mode_err", mode_err, expErr);
    checkOutput("active_mode", active_mode, mActive);
    if (out_valid && out_ready) delivered++;
    acc   = in_valid && adv;
    apply = acc && (next_x == 0) && (next_y == 0) && mPendV;
    eff   = apply ? mPend : mActive;
    e     = refMap(eff, int'(next_x), int'(next_y));
    nDone = apply;
    nErr  = mode_req && (int'(ch) >= 5);
    lastAccepted = acc;
    @(posedge clk_in);
    if (adv) begin
      slotV[2] = slotV[1]; slotE[2] = slotE[1];
      slotV[1] = slotV[0]; slotE[1] = slotE[0];
      slotV[0] = in_valid; slotE[0] = e;
    end
    if (apply) begin
      mActive = mPend;
      mPendV  = 1'b0;
    end
    if (mode_req && int'(ch) < 5) begin
      mPend  = int'(ch);
      mPendV = 1'b1;
    end
    expDone = nDone;
    expErr  = nErr;
    @(negedge clk_in);
  endtask

  // Assert reset across a rising edge and check the cleared state. Then
  // release reset on a falling edge.
  task automatic doReset();
    applyStimulus(0, 0, 0, 0, 0, 1);
    reset = 1'b0;
    @(posedge clk_in);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_img_x", img_x, 0);
    checkOutput("rst_img_y", img_y, 0);
    checkOutput("rst_in_img", in_img, 0);
    checkOutput("rst_address", address, 0);
    checkOutput("rst_mode_done", mode_done, 0);
    checkOutput("rst_mode_err", mode_err, 0);
    checkOutput("rst_active_mode", active_mode, 0);
    modelReset();
    @(negedge clk_in);
    reset = 1'b1;
  endtask

  task automatic drain(input int n);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Request a mode and apply it with a frame-start beat.
  task automatic setMode(input int m);
    applyStimulus(0, 0, 0, 1, m, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    checkOutput("setmode_active", active_mode, m);
    drain(4);
    curMode = m;
  endtask

  vecT vecs[$];
  int  doneCnt;
  int  idx;
  int  rx, ry, rc;
  bit  rv, rreq, rrdy;

  initial begin
    vecs.push_back('{0, 160, 120, 1'b1, 0, 0, 0});
    vecs.push_back('{0, 159, 120, 1'b0, 0, 0, 0});
    vecs.push_back('{1, 639, 479, 1'b1, 319, 239, 76799});
    vecs.push_back('{1, 0, 0, 1'b1, 0, 0, 0});
    vecs.push_back('{2, 0, 0, 1'b1, 80, 60, 19280});
    vecs.push_back('{2, 639, 479, 1'b1, 239, 179, 57519});
    vecs.push_back('{3, 242, 181, 1'b1, 4, 2, 644});
    vecs.push_back('{3, 400, 300, 1'b0, 0, 0, 0});
    vecs.push_back('{4, 359, 269, 1'b1, 316, 236, 75836});
    vecs.push_back('{4, 360, 210, 1'b0, 0, 0, 0});

    delivered = 0;
    doReset();

    // Directed vectors. Each result must appear exactly 3 edges after its beat.
    foreach (vecs[i]) begin
      if (vecs[i].mode != curMode) setMode(vecs[i].mode);
      applyStimulus(1, vecs[i].x, vecs[i].y, 0, 0, 1);
      tick();
      applyStimulus(0, 0, 0, 0, 0, 1);
      tick();
      tick();
      checkOutput("vec_valid", out_valid, 1);
      checkOutput("vec_in_img", in_img, vecs[i].inImg);
      checkOutput("vec_img_x", img_x, vecs[i].ix);
      checkOutput("vec_img_y", img_y, vecs[i].iy);
      checkOutput("vec_address", address, vecs[i].addr);
      tick();
    end

    // A request made mid-frame waits for the frame start.
    setMode(0);
    doneCnt = 0;
    applyStimulus(1, 100, 50, 1, 3, 1);
    tick(); doneCnt += int'(mode_done);
    checkOutput("chg_hold0", active_mode, 0);
    applyStimulus(1, 101, 50, 0, 0, 1);
    tick(); doneCnt += int'(mode_done);
    applyStimulus(1, 102, 50, 0, 0, 1);
    tick(); doneCnt += int'(mode_done);
    checkOutput("chg_hold1", active_mode, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick(); doneCnt += int'(mode_done);
    checkOutput("chg_active3", active_mode, 3);
    applyStimulus(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      tick(); doneCnt += int'(mode_done);
    end
    checkOutput("chg_done_once", doneCnt, 1);

    // An invalid code raises the error pulse and leaves the mode unchanged.
    applyStimulus(0, 0, 0, 1, 6, 1);
    tick();
    checkOutput("err_pulse", mode_err, 1);
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("err_clear", mode_err, 0);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("err_mode_kept", active_mode, 3);
    checkOutput("err_no_done", mode_done, 0);
    drain(3);

    // A request made in the same cycle as a frame-start beat waits for the
    // next frame start.
    applyStimulus(1, 0, 0, 1, 1, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("same_cycle_kept", active_mode, 3);
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    checkOutput("same_cycle_next", active_mode, 1);
    drain(4);

    // A later request overwrites a pending request that was never applied.
    applyStimulus(0, 0, 0, 1, 2, 1);
    tick();
    applyStimulus(0, 0, 0, 1, 4, 1);
    tick();
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    checkOutput("overwrite_mode", active_mode, 4);
    drain(4);

    // Backpressure: send 8 beats and stall the output for 5 cycles mid-stream.
    setMode(0);
    delivered = 0;
    idx = 0;
    for (int c = 0; c < 40 && delivered < 8; c++) begin
      if (idx < 8) applyStimulus(1, 150 + 3 * idx, 118 + idx, 0, 0, !(c >= 4 && c < 9));
      else         applyStimulus(0, 0, 0, 0, 0, !(c >= 4 && c < 9));
      tick();
      if (lastAccepted) idx++;
    end
    checkOutput("bp_accepted", idx, 8);
    checkOutput("bp_delivered", delivered, 8);
    drain(3);

    // Randomized stream with random stalls, frame starts and mode requests.
    for (int i = 0; i < 600; i++) begin
      rv   = ($urandom_range(0, 3) != 0);
      rrdy = ($urandom_range(0, 3) != 0);
      rreq = ($urandom_range(0, 11) == 0);
      rc   = int'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) begin
        rx = 0; ry = 0;
      end else begin
        rx = int'($urandom_range(0, DST_W - 1));
        ry = int'($urandom_range(0, DST_H - 1));
      end
      applyStimulus(rv, rx, ry, rreq, rc, rrdy);
      tick();
    end
    drain(4);

    // Reset during a stream flushes the pipeline and discards the pending mode.
    applyStimulus(0, 0, 0, 1, 2, 1);
    tick();
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1, 300 + i, 200, 0, 0, 1);
      tick();
    end
    checkOutput("midrst_pre_valid", out_valid, 1);
    reset = 1'b0;
    #1;
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_active", active_mode, 0);
    doReset();
    applyStimulus(1, 0, 0, 0, 0, 1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1);
    tick();
    checkOutput("midrst_no_pending", active_mode, 0);
    checkOutput("midrst_no_done", mode_done, 0);
    drain(3);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
